pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter: WAIT_LIMIT, 64, max consecutive memory-wait cycles before halt (range 1..255).
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: rs1_DE, rs2_DE  in  5 each  source registers of the instruction in DE.
REQ-005 SHALL have ports: rs1_EX, rs2_EX, rd_EX  in  5 each  sources and destination of the instruction in EX.
REQ-006 SHALL have ports: mem_read_en_EX, rf_write_en_EX  in  1 each  EX load and writeback flags.
REQ-007 SHALL have ports: rd_MEM, rd_WB  in  5 each; rf_write_en_MEM, rf_write_en_WB  in  1 each.
REQ-008 SHALL have ports: BP_en_EX, BP_decision_EX  in  1 each  prediction valid and predicted-taken.
REQ-009 SHALL have ports: taken_EX  in  1  resolved branch taken, or JAL/JALR.
REQ-010 SHALL have ports: mem_req_MEM  in  1  MEM-stage load/store active; mem_ready  in  1  data memory done.
REQ-011 SHALL have outputs: stall_F, stall_DE, flush_DE, flush_EX, freeze, redirect_EX  out  1 each.
REQ-012 SHALL have outputs: fwd_a_EX, fwd_b_EX  out  2 each  00 regfile, 01 WB, 10 MEM.
REQ-013 SHALL have outputs: halted  out  1  sticky timeout; stall_cnt, flush_cnt  out  32 each.

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT, HALT.
REQ-015 SHALL go RUN->MEM_WAIT when mem_req_MEM=1 and mem_ready=0; MEM_WAIT->RUN on mem_ready=1.
REQ-016 SHALL go MEM_WAIT->HALT when the 8-bit wait counter equals WAIT_LIMIT without mem_ready; HALT is left only by reset.
REQ-017 SHALL clear the wait counter on entry to MEM_WAIT and increment it once per MEM_WAIT cycle.
REQ-018 SHALL assert freeze, stall_F and stall_DE combinationally whenever (RUN and mem_req_MEM and !mem_ready), or in MEM_WAIT, or in HALT.
REQ-019 SHALL drive redirect_EX=1 when (BP_en_EX ? BP_decision_EX : 0) != taken_EX, i.e. predicted and resolved direction differ.
REQ-020 SHALL, on redirect_EX while not frozen, assert flush_DE and flush_EX for that cycle only, with stall_F=stall_DE=0.
REQ-021 SHALL detect load-use when mem_read_en_EX, rf_write_en_EX, rd_EX!=0 and rd_EX matches rs1_DE or rs2_DE.
REQ-022 SHALL, on load-use while not frozen and without redirect, assert stall_F, stall_DE and flush_EX for exactly one cycle.
REQ-023 SHALL apply priority freeze > redirect > load-use; while frozen, flush_DE=flush_EX=0 and redirect_EX is suppressed to 0.
REQ-024 SHALL select fwd_a_EX=10 if rf_write_en_MEM, rd_MEM!=0 and rd_MEM==rs1_EX; else 01 on the same WB match; else 00. fwd_b_EX is the same function of rs2_EX.
REQ-025 SHALL never forward for register x0.

Reset
REQ-026 SHALL, on rst low, immediately enter RUN, clear the wait counter, halted, stall_cnt and flush_cnt.
REQ-027 SHALL, on reset asserted mid-MEM_WAIT or in HALT, deassert freeze once rst is low and inputs are idle.

Configuration
REQ-028 SHALL, with HAZ_PERF_CNT_EN defined, increment stall_cnt on every cycle with stall_DE=1 and flush_cnt on every cycle with flush_EX=1; both wrap modulo 2^32.
REQ-029 SHALL, without HAZ_PERF_CNT_EN, tie stall_cnt and flush_cnt to 0 and implement no counter flops.

Verification
REQ-030 SHALL cover: rd_EX=5 load, rs2_DE=5 -> one cycle stall_F=stall_DE=flush_EX=1, then released; same with rd_EX=0 -> no stall.
REQ-031 SHALL cover: BP_en_EX=1, BP_decision_EX=1, taken_EX=0 -> redirect_EX=flush_DE=flush_EX=1 for one cycle; load-use in the same cycle -> stall_DE=0.
REQ-032 SHALL cover: rd_MEM=rd_WB=rs1_EX=7, both write-enabled -> fwd_a_EX=10; with rf_write_en_MEM=0 -> fwd_a_EX=01.
REQ-033 SHALL cover: mem_req_MEM=1, mem_ready low 3 cycles -> freeze high 4 cycles, no flush during freeze.
REQ-034 SHALL cover: WAIT_LIMIT=4, mem_ready stuck low -> halted=1 and HALT persists; rst pulse -> RUN, halted=0.
REQ-035 SHALL cover: with HAZ_PERF_CNT_EN, 3 stall cycles and 2 flush cycles -> stall_cnt=3, flush_cnt=2.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard unit for a 5-stage pipeline: memory-wait freeze FSM, branch redirect, load-use stall, operand forwarding.
// Optional performance counters are built in when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_controller #(
  parameter int WAIT_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_DE,
  input  logic [4:0]  rs2_DE,
  input  logic [4:0]  rs1_EX,
  input  logic [4:0]  rs2_EX,
  input  logic [4:0]  rd_EX,
  input  logic        mem_read_en_EX,
  input  logic        rf_write_en_EX,
  input  logic [4:0]  rd_MEM,
  input  logic [4:0]  rd_WB,
  input  logic        rf_write_en_MEM,
  input  logic        rf_write_en_WB,
  input  logic        BP_en_EX,
  input  logic        BP_decision_EX,
  input  logic        taken_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ready,
  output logic        stall_F,
  output logic        stall_DE,
  output logic        flush_DE,
  output logic        flush_EX,
  output logic        freeze,
  output logic        redirect_EX,
  output logic [1:0]  fwd_a_EX,
  output logic [1:0]  fwd_b_EX,
  output logic        halted,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LIMIT_W = 8'(WAIT_LIMIT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mispredict;
  logic       load_use;
  logic       lu_stall;

  // Memory handshake: a MEM-stage access (mem_req_MEM) completes in the cycle
  // mem_ready is high; every cycle it is requested without mem_ready is a wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      halted   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req_MEM && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LIMIT_W) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign fsm_state = state;

  // The initial miss cycle freezes combinationally, before the FSM has moved.
  assign freeze = (state != RUN) || (mem_req_MEM && !mem_ready);

  assign mispredict = ((BP_en_EX && BP_decision_EX) != taken_EX);
  assign load_use   = mem_read_en_EX && rf_write_en_EX && (rd_EX != 5'd0) &&
                      ((rd_EX == rs1_DE) || (rd_EX == rs2_DE));
  assign lu_stall   = !freeze && !mispredict && load_use;

  assign redirect_EX = !freeze && mispredict;
  assign stall_F     = freeze || lu_stall;
  assign stall_DE    = freeze || lu_stall;
  assign flush_DE    = redirect_EX;
  assign flush_EX    = redirect_EX || lu_stall;

  always_comb begin
    fwd_a_EX = 2'b00;
    if (rf_write_en_MEM && (rd_MEM != 5'd0) && (rd_MEM == rs1_EX))
      fwd_a_EX = 2'b10;
    else if (rf_write_en_WB && (rd_WB != 5'd0) && (rd_WB == rs1_EX))
      fwd_a_EX = 2'b01;
  end

  always_comb begin
    fwd_b_EX = 2'b00;
    if (rf_write_en_MEM && (rd_MEM != 5'd0) && (rd_MEM == rs2_EX))
      fwd_b_EX = 2'b10;
    else if (rf_write_en_WB && (rd_WB != 5'd0) && (rd_WB == rs2_EX))
      fwd_b_EX = 2'b01;
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_DE) stall_cnt <= stall_cnt + 32'd1;
      if (flush_EX) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios then random traffic
// checked every cycle against a rule-level reference model.
module tb_pipeline_hazard_controller;

  localparam int WL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_DE, rs2_DE, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
  logic        mem_read_en_EX, rf_write_en_EX, rf_write_en_MEM, rf_write_en_WB;
  logic        BP_en_EX, BP_decision_EX, taken_EX, mem_req_MEM, mem_ready;
  logic        stall_F, stall_DE, flush_DE, flush_EX, freeze, redirect_EX, halted;
  logic [1:0]  fwd_a_EX, fwd_b_EX, fsm_state;
  logic [31:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          miss_run;
  bit          halted_m;
  logic [31:0] sc_m, fc_m;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst),
    .rs1_DE(rs1_DE), .rs2_DE(rs2_DE), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
    .mem_read_en_EX(mem_read_en_EX), .rf_write_en_EX(rf_write_en_EX),
    .rd_MEM(rd_MEM), .rd_WB(rd_WB), .rf_write_en_MEM(rf_write_en_MEM), .rf_write_en_WB(rf_write_en_WB),
    .BP_en_EX(BP_en_EX), .BP_decision_EX(BP_decision_EX), .taken_EX(taken_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .stall_F(stall_F), .stall_DE(stall_DE), .flush_DE(flush_DE), .flush_EX(flush_EX),
    .freeze(freeze), .redirect_EX(redirect_EX), .fwd_a_EX(fwd_a_EX), .fwd_b_EX(fwd_b_EX),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fsm_state(fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (rf_write_en_MEM && rd_MEM == rs) return 2'b10;
    if (rf_write_en_WB && rd_WB == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    rs1_DE = 0; rs2_DE = 0; rs1_EX = 0; rs2_EX = 0; rd_EX = 0; rd_MEM = 0; rd_WB = 0;
    mem_read_en_EX = 0; rf_write_en_EX = 0; rf_write_en_MEM = 0; rf_write_en_WB = 0;
    BP_en_EX = 0; BP_decision_EX = 0; taken_EX = 0; mem_req_MEM = 0; mem_ready = 1;
  endtask

  // Inputs are applied at a negedge; check just after, advance the model, then wait for the next negedge.
  task automatic step();
    bit frz, mis, lu, redir, lus, stl, fex;
    #1;
    frz   = halted_m || (miss_run > 0) || (mem_req_MEM && !mem_ready);
    mis   = ((BP_en_EX && BP_decision_EX) != taken_EX);
    lu    = mem_read_en_EX && rf_write_en_EX && rd_EX != 0 && (rd_EX == rs1_DE || rd_EX == rs2_DE);
    redir = !frz && mis;
    lus   = !frz && !mis && lu;
    stl   = frz || lus;
    fex   = redir || lus;
    chk("freeze", freeze, frz);
    chk("stall_F", stall_F, stl);
    chk("stall_DE", stall_DE, stl);
    chk("flush_DE", flush_DE, redir);
    chk("flush_EX", flush_EX, fex);
    chk("redirect_EX", redirect_EX, redir);
    chk("fwd_a_EX", fwd_a_EX, fwd_ref(rs1_EX));
    chk("fwd_b_EX", fwd_b_EX, fwd_ref(rs2_EX));
    chk("halted", halted, halted_m);
    chk("stall_cnt", stall_cnt, sc_m);
    chk("flush_cnt", flush_cnt, fc_m);
    if (!halted_m) begin
      if (frz && !mem_ready) begin
        miss_run++;
        if (miss_run == WL + 2) halted_m = 1;
      end else begin
        miss_run = 0;
      end
    end
`ifdef HAZ_PERF_CNT_EN
    if (stl) sc_m = sc_m + 32'd1;
    if (fex) fc_m = fc_m + 32'd1;
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #1;
    miss_run = 0; halted_m = 0; sc_m = 0; fc_m = 0;
    chk("rst_halted", halted, 1'b0);
    chk("rst_freeze", freeze, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    miss_run = 0; halted_m = 0; sc_m = 0; fc_m = 0;
    @(negedge clk);
    do_reset();

    // load-use on rd=5 stalls one cycle, then the bubble releases it
    mem_read_en_EX = 1; rf_write_en_EX = 1; rd_EX = 5; rs2_DE = 5; rs1_DE = 3;
    #1 chk("lu_stall", {stall_F, stall_DE, flush_EX}, 3'b111);
    step();
    mem_read_en_EX = 0; rf_write_en_EX = 0; rd_EX = 0;
    #1 chk("lu_release", {stall_F, stall_DE, flush_EX}, 3'b000);
    step();
    // x0 destination never stalls
    mem_read_en_EX = 1; rf_write_en_EX = 1; rd_EX = 0; rs1_DE = 0; rs2_DE = 0;
    #1 chk("lu_x0", stall_DE, 1'b0);
    step();

    // mispredict wins over load-use
    mem_read_en_EX = 1; rf_write_en_EX = 1; rd_EX = 5; rs2_DE = 5;
    BP_en_EX = 1; BP_decision_EX = 1; taken_EX = 0;
    #1 chk("redir_flush", {redirect_EX, flush_DE, flush_EX, stall_DE}, 4'b1110);
    step();
    idle();
    step();

    // forwarding priority MEM over WB
    rd_MEM = 7; rd_WB = 7; rs1_EX = 7; rf_write_en_MEM = 1; rf_write_en_WB = 1;
    #1 chk("fwd_mem", fwd_a_EX, 2'b10);
    step();
    rf_write_en_MEM = 0;
    #1 chk("fwd_wb", fwd_a_EX, 2'b01);
    step();
    rd_MEM = 0; rd_WB = 0; rs2_EX = 0; rf_write_en_MEM = 1;
    #1 chk("fwd_x0", fwd_b_EX, 2'b00);
    step();
    idle();

    // 3 wait cycles -> 4 freeze cycles, mispredict suppressed meanwhile
    mem_req_MEM = 1; mem_ready = 0; BP_en_EX = 1; BP_decision_EX = 1; taken_EX = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("wait_freeze", {freeze, flush_DE, flush_EX, redirect_EX}, 4'b1000);
      step();
    end
    mem_ready = 1;
    #1 chk("wait_last", {freeze, flush_DE, flush_EX}, 3'b100);
    step();
    mem_req_MEM = 0; BP_en_EX = 0; taken_EX = 0;
    #1 chk("wait_done", freeze, 1'b0);
    step();

    // stuck memory -> halt, sticky until reset
    mem_req_MEM = 1; mem_ready = 0;
    for (int i = 0; i < WL + 3; i++) step();
    chk("halt_set", halted, 1'b1);
    mem_req_MEM = 0; mem_ready = 1;
    for (int i = 0; i < 3; i++) step();
    chk("halt_sticky", {halted, freeze}, 2'b11);
    do_reset();
    #1 chk("halt_cleared", {halted, freeze}, 2'b00);
    step();

    // 3 stall cycles (freeze) then 2 flush cycles (mispredict) from fresh counters
    do_reset();
    mem_req_MEM = 1; mem_ready = 0;
    step(); step();
    mem_ready = 1;
    step();
    mem_req_MEM = 0;
    taken_EX = 1;
    step(); step();
    taken_EX = 0;
    #1;
`ifdef HAZ_PERF_CNT_EN
    chk("perf_stall", stall_cnt, 32'd3);
    chk("perf_flush", flush_cnt, 32'd2);
`else
    chk("perf_stall_off", stall_cnt, 32'd0);
    chk("perf_flush_off", flush_cnt, 32'd0);
`endif
    step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if (halted_m && $urandom_range(0, 5) == 0) begin
        do_reset();
        continue;
      end
      rs1_DE = 5'($urandom_range(0, 7)); rs2_DE = 5'($urandom_range(0, 7));
      rs1_EX = 5'($urandom_range(0, 7)); rs2_EX = 5'($urandom_range(0, 7));
      rd_EX  = 5'($urandom_range(0, 7)); rd_MEM = 5'($urandom_range(0, 7));
      rd_WB  = 5'($urandom_range(0, 7));
      mem_read_en_EX  = 1'($urandom); rf_write_en_EX = 1'($urandom);
      rf_write_en_MEM = 1'($urandom); rf_write_en_WB = 1'($urandom);
      BP_en_EX = 1'($urandom); BP_decision_EX = 1'($urandom); taken_EX = 1'($urandom);
      mem_req_MEM = ($urandom_range(0, 9) < 3);
      mem_ready   = ($urandom_range(0, 9) >= 4);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
